// File: rtl/vram_arbiter.sv
// vram_arbiter: two-client round-robin arbiter with bounded bursts in front of a
// synchronous single-port video RAM; registers every access and returns read data by tag.
module vram_arbiter #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 8
) (
   input  logic                  clk,
   input  logic                  rst_,
   input  logic [DATA_W-1:0]     c0_in_data,
   input  logic [ADDR_W-1:0]     c0_in_addr,
   input  logic [DATA_W/8-1:0]   c0_in_wben,
   input  logic                  c0_in_op,
   input  logic                  c0_in_rts,
   output logic                  c0_out_rtr,
   output logic [DATA_W-1:0]     c0_out_rdata,
   output logic                  c0_out_rvalid,
   input  logic [DATA_W-1:0]     c1_in_data,
   input  logic [ADDR_W-1:0]     c1_in_addr,
   input  logic [DATA_W/8-1:0]   c1_in_wben,
   input  logic                  c1_in_op,
   input  logic                  c1_in_rts,
   output logic                  c1_out_rtr,
   output logic [DATA_W-1:0]     c1_out_rdata,
   output logic                  c1_out_rvalid,
   output logic                  mem_en,
   output logic [DATA_W/8-1:0]   mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata
);
   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   logic              owner_q, owner_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              gnt, sel, op, sat;
   logic              en_q, en_d;
   logic [BE_W-1:0]   we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              t1_v_q, t1_v_d, t1_id_q, t1_id_d, t2_v_q, t2_id_q;
   logic              rv0_q, rv0_d, rv1_q, rv1_d;
   logic [DATA_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
   always_comb begin
      sat        = cnt_q >= CNT_W'(MAX_BURST);
      gnt        = (c0_in_rts | c1_in_rts) & rst_;
      // client 1 wins when alone, or when it owns an unexpired burst, or when client 0's burst expired
      sel        = c1_in_rts & (~c0_in_rts | (owner_q ^ sat));
      c0_out_rtr = gnt & ~sel;
      c1_out_rtr = gnt & sel;
      op         = sel ? c1_in_op : c0_in_op;
      owner_d    = gnt ? sel : owner_q;
      cnt_d      = !gnt ? '0 : (sel != owner_q) ? CNT_W'(1) : sat ? cnt_q : cnt_q + 1'b1;
      en_d       = gnt;
      addr_d     = !gnt ? '0 : sel ? c1_in_addr : c0_in_addr;
      we_d       = !(gnt & op) ? '0 : sel ? c1_in_wben : c0_in_wben;
      wdata_d    = !(gnt & op) ? '0 : sel ? c1_in_data : c0_in_data;
      t1_v_d     = gnt & ~op;
      t1_id_d    = sel;
      rv0_d      = t2_v_q & ~t2_id_q;
      rv1_d      = t2_v_q & t2_id_q;
      rd0_d      = rv0_d ? mem_rdata : rd0_q;
      rd1_d      = rv1_d ? mem_rdata : rd1_q;
   end
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         owner_q <= 1'b0;
         cnt_q   <= '0;
         en_q    <= 1'b0;
         we_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         t1_v_q  <= 1'b0;
         t1_id_q <= 1'b0;
         t2_v_q  <= 1'b0;
         t2_id_q <= 1'b0;
         rv0_q   <= 1'b0;
         rv1_q   <= 1'b0;
         rd0_q   <= '0;
         rd1_q   <= '0;
      end else begin
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         t1_v_q  <= t1_v_d;
         t1_id_q <= t1_id_d;
         t2_v_q  <= t1_v_q;
         t2_id_q <= t1_id_q;
         rv0_q   <= rv0_d;
         rv1_q   <= rv1_d;
         rd0_q   <= rd0_d;
         rd1_q   <= rd1_d;
      end
   end
   assign mem_en        = en_q;
   assign mem_we        = we_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign c0_out_rvalid = rv0_q;
   assign c1_out_rvalid = rv1_q;
   assign c0_out_rdata  = rd0_q;
   assign c1_out_rdata  = rd1_q;
endmodule
